shift_sequencer: RTL and testbench

- Multicycle shift unit controller for the ALU shift path.
- Decomposes a 5-bit shift amount into power-of-two stages (16, 8, 4, 2, 1) and applies one stage per clock to an internal working register.
- A single SLL/SRL/SRA stage datapath is thereby reused instead of a full combinational barrel.
- Sits between the execute-stage issue logic (valid/ready in) and the ALU result mux (valid/ready out).

---
 rtl/shift_sequencer_if.sv | 27 ++
 rtl/shift_sequencer.sv | 155 +++++++++++++++
 tb/tb_shift_sequencer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/shift_sequencer_if.sv
// Handshake bundle between issue logic, shift_sequencer and the ALU result mux.
// master = requester/consumer side, slave = the sequencer.
interface shift_sequencer_if #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
);
    logic               in_valid;
    logic               in_ready;
    logic [DATA_W-1:0]  B;
    logic [SHAMT_W-1:0] shamt;
    logic [1:0]         ALUfun;
    logic               abort;
    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  result;
    logic               busy;

    modport master (
        output in_valid, B, shamt, ALUfun, abort, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, B, shamt, ALUfun, abort, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/shift_sequencer.sv
// Multicycle shifter: one power-of-two stage (16,8,4,2,1) per clock on a working register.
// Define SHIFT_SEQ_SKIP_ZERO_EN to visit only stages whose shamt bit is set.
module shift_sequencer #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    shift_sequencer_if.slave  bus
);
    localparam int IDX_W = (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   stage_reg, stage_next;
    logic [DATA_W-1:0]  work_reg, work_next;
    logic [SHAMT_W-1:0] shamt_reg, shamt_next;
    logic [1:0]         fun_reg, fun_next;
    logic [DATA_W-1:0]  result_reg, result_next;
    logic               out_valid_reg, out_valid_next;

    logic               in_ready;
    logic               accept;
    logic [DATA_W-1:0]  stage_out [SHAMT_W];
    logic [DATA_W-1:0]  shifted;

    // One fixed-distance shifter per stage; only the current stage's output is used.
    genvar gi;
    generate
        for (gi = 0; gi < SHAMT_W; gi++) begin : g_stage
            logic signed [DATA_W-1:0] sra_val;
            assign sra_val = $signed(work_reg) >>> (1 << gi);
            assign stage_out[gi] = fun_reg[1] ? $unsigned(sra_val)
                                 : (fun_reg[0] ? (work_reg >> (1 << gi))
                                               : (work_reg << (1 << gi)));
        end
    endgenerate

    always_comb begin
        shifted = work_reg;
        for (int i = 0; i < SHAMT_W; i++) begin
            if (stage_reg == IDX_W'(i)) shifted = stage_out[i];
        end
    end

`ifdef SHIFT_SEQ_SKIP_ZERO_EN
    function automatic logic [IDX_W-1:0] top_bit(input logic [SHAMT_W-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < SHAMT_W; i++) begin
            if (v[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction
`endif

    assign in_ready = !bus.abort &&
                      ((state_reg == IDLE) || ((state_reg == DONE) && bus.out_ready));
    assign accept   = bus.in_valid && in_ready;

    always_comb begin
`ifdef SHIFT_SEQ_SKIP_ZERO_EN
        logic [SHAMT_W-1:0] pending;
        pending        = '0;
`endif
        state_next     = state_reg;
        stage_next     = stage_reg;
        work_next      = work_reg;
        shamt_next     = shamt_reg;
        fun_next       = fun_reg;
        result_next    = result_reg;
        out_valid_next = out_valid_reg;

        if (bus.abort) begin
            // Flush wins over everything; result keeps its last value.
            state_next     = IDLE;
            out_valid_next = 1'b0;
        end else begin
            case (state_reg)
                SHIFT: begin
`ifdef SHIFT_SEQ_SKIP_ZERO_EN
                    // shamt_reg holds the bits still to apply; stage_reg is its top set bit.
                    work_next  = shifted;
                    pending    = shamt_reg & ~(SHAMT_W'(1) << stage_reg);
                    shamt_next = pending;
                    stage_next = top_bit(pending);
                    if (pending == '0) begin
                        state_next     = DONE;
                        result_next    = shifted;
                        out_valid_next = 1'b1;
                    end
`else
                    if (shamt_reg[stage_reg]) work_next = shifted;
                    if (stage_reg == '0) begin
                        state_next     = DONE;
                        result_next    = work_next;
                        out_valid_next = 1'b1;
                    end else begin
                        stage_next = stage_reg - 1'b1;
                    end
`endif
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_next     = IDLE;
                        out_valid_next = 1'b0;
                    end
                end
                default: ;
            endcase

            if (accept) begin
                work_next  = bus.B;
                shamt_next = bus.shamt;
                fun_next   = bus.ALUfun;
                state_next = SHIFT;
                stage_next = IDX_W'(SHAMT_W - 1);
`ifdef SHIFT_SEQ_SKIP_ZERO_EN
                stage_next = top_bit(bus.shamt);
                if (bus.shamt == '0) begin
                    state_next     = DONE;
                    result_next    = bus.B;
                    out_valid_next = 1'b1;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            stage_reg     <= IDX_W'(SHAMT_W - 1);
            work_reg      <= '0;
            shamt_reg     <= '0;
            fun_reg       <= '0;
            result_reg    <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            stage_reg     <= stage_next;
            work_reg      <= work_next;
            shamt_reg     <= shamt_next;
            fun_reg       <= fun_next;
            result_reg    <= result_next;
            out_valid_reg <= out_valid_next;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_reg;
    assign bus.result    = result_reg;
    assign bus.busy      = (state_reg != IDLE);
endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer; latency expectations follow SHIFT_SEQ_SKIP_ZERO_EN.
module tb_shift_sequencer;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    shift_sequencer_if bus ();

    shift_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int exp_lat(input logic [4:0] sh);
`ifdef SHIFT_SEQ_SKIP_ZERO_EN
        return $countones(sh);
`else
        return (sh == 5'd0) ? 5 : 5;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic do_req(input string tag, input logic [31:0] b, input logic [4:0] sh,
                          input logic [1:0] fn, input logic [31:0] exp);
        int n;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.B        = b;
        bus.shamt    = sh;
        bus.ALUfun   = fn;
        tick();
        bus.in_valid = 1'b0;
        wait_valid(n);
        check({tag, "_lat"}, 32'(n), 32'(exp_lat(sh)));
        check({tag, "_res"}, bus.result, exp);
        $display("txn %s B=%h shamt=%0d fun=%b result=%h lat=%0d", tag, b, sh, fn, bus.result, n);
        tick();
        check({tag, "_drain"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        int n;
        int rises;
        total         = 0;
        bad           = 0;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.B         = '0;
        bus.shamt     = '0;
        bus.ALUfun    = '0;
        bus.abort     = 1'b0;
        bus.out_ready = 1'b1;

        repeat (2) tick();
        check("rst_ov",   32'(bus.out_valid), 32'd0);
        check("rst_busy", 32'(bus.busy),      32'd0);
        check("rst_res",  bus.result,         32'd0);
        reset = 1'b0;
        #1;
        check("rst_rdy",  32'(bus.in_ready),  32'd1);

        do_req("sll31",   32'h0000_0001, 5'd31, 2'b00, 32'h8000_0000);
        do_req("sra4",    32'h8000_0000, 5'd4,  2'b11, 32'hF800_0000);
        do_req("srl8",    32'hF000_000F, 5'd8,  2'b01, 32'h00F0_0000);
        do_req("sra10",   32'h8000_0000, 5'd1,  2'b10, 32'hC000_0000);
        do_req("sra_pos", 32'h7000_0000, 5'd4,  2'b11, 32'h0700_0000);
        do_req("zero",    32'hDEAD_BEEF, 5'd0,  2'b00, 32'hDEAD_BEEF);
        do_req("srl5",    32'h8000_0000, 5'd5,  2'b01, 32'h0400_0000);

        // Backpressure in DONE, then back-to-back accept on release.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.B         = 32'h0000_0003;
        bus.shamt     = 5'd2;
        bus.ALUfun    = 2'b00;
        tick();
        bus.in_valid  = 1'b0;
        wait_valid(n);
        check("bp_res", bus.result, 32'h0000_000C);
        bus.in_valid  = 1'b1;
        bus.B         = 32'h0000_00FF;
        bus.shamt     = 5'd4;
        bus.ALUfun    = 2'b00;
        for (int i = 0; i < 3; i++) begin
            check("bp_hold_ov",  32'(bus.out_valid), 32'd1);
            check("bp_hold_res", bus.result,         32'h0000_000C);
            check("bp_hold_rdy", 32'(bus.in_ready),  32'd0);
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        check("b2b_rdy", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        check("b2b_ov",   32'(bus.out_valid), 32'd0);
        check("b2b_busy", 32'(bus.busy),      32'd1);
        wait_valid(n);
        check("b2b_lat", 32'(n), 32'(exp_lat(5'd4)));
        check("b2b_res", bus.result, 32'h0000_0FF0);
        $display("txn b2b B=000000ff shamt=4 fun=00 result=%h lat=%0d", bus.result, n);
        tick();

        // Abort sampled on the second edge after accept, with a competing request.
        bus.in_valid = 1'b1;
        bus.B        = 32'h1234_5678;
        bus.shamt    = 5'd12;
        bus.ALUfun   = 2'b00;
        tick();
        bus.in_valid = 1'b0;
        tick();
        bus.abort    = 1'b1;
        bus.in_valid = 1'b1;
        bus.B        = 32'hAAAA_AAAA;
        #1;
        check("abort_rdy0", 32'(bus.in_ready), 32'd0);
        tick();
        bus.abort    = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check("abort_busy", 32'(bus.busy),      32'd0);
        check("abort_ov",   32'(bus.out_valid), 32'd0);
        check("abort_rdy1", 32'(bus.in_ready),  32'd1);
        rises = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.out_valid) rises++;
        end
        check("abort_norise", 32'(rises), 32'd0);
        check("abort_keep",   bus.result, 32'h0000_0FF0);
        $display("txn abort B=12345678 shamt=12 result=%h", bus.result);
        do_req("post_abort", 32'h1234_5678, 5'd12, 2'b00, 32'h4567_8000);

        // Async reset in the middle of SHIFT.
        bus.in_valid = 1'b1;
        bus.B        = 32'hFFFF_FFFF;
        bus.shamt    = 5'd31;
        bus.ALUfun   = 2'b01;
        tick();
        bus.in_valid = 1'b0;
        tick();
        #2;
        reset = 1'b1;
        #1;
        check("arst_busy", 32'(bus.busy),      32'd0);
        check("arst_ov",   32'(bus.out_valid), 32'd0);
        check("arst_res",  bus.result,         32'd0);
        $display("txn async_reset result=%h busy=%0d", bus.result, bus.busy);
        tick();
        reset = 1'b0;
        #1;
        do_req("post_rst", 32'h0000_0001, 5'd0, 2'b00, 32'h0000_0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
